// File: rtl/usb_tx_buffer.sv
// Byte FIFO between the SD reader and the USB transmitter: show-ahead head byte,
// packet-ready tracking and a running USB data CRC16 over popped bytes.
module usb_tx_buffer #(
    parameter int DEPTH     = 64,
    parameter int PKT_BYTES = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     wr_last,
    input  logic                     fifo_en,
    output logic [7:0]               parallel_in,
    output logic                     buff_empty,
    output logic                     buff_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_ready,
    output logic [15:0]              crc16,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_BYTES);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   crc_reg;
    logic          push_ok, pop_ok;
    logic [CW-1:0] count_nxt;

    // A pop at full frees the slot the simultaneous push needs.
    assign pop_ok    = fifo_en && !buff_empty;
    assign push_ok   = wr_en && (!buff_full || fifo_en);
    assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);

    assign parallel_in = buff_empty ? 8'h00 : mem[rd_ptr];
    assign crc16       = ~crc_reg;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Storage carries no reset; stale bytes are masked by buff_empty.
    always_ff @(posedge clk) begin
        if (!clear && push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            buff_empty <= 1'b1;
            buff_full  <= 1'b0;
            pkt_ready  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            crc_reg    <= 16'hFFFF;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            buff_empty <= 1'b1;
            buff_full  <= 1'b0;
            pkt_ready  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            crc_reg    <= 16'hFFFF;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                crc_reg <= crc_upd(crc_reg, mem[rd_ptr]);
            end
            count      <= count_nxt;
            buff_empty <= (count_nxt == '0);
            buff_full  <= (count_nxt == FULL_CNT);
            if ((push_ok && wr_last) || count_nxt >= PKT_CNT) pkt_ready <= 1'b1;
            else if (count_nxt == '0)                        pkt_ready <= 1'b0;
            if (wr_en && buff_full && !fifo_en) overflow  <= 1'b1;
            if (fifo_en && buff_empty)          underflow <= 1'b1;
        end
    end
endmodule

// File: doc/usb_tx_buffer.md
USB_TX_BUFFER -- requirements
Module: usb_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64: byte capacity; power of two, at least 4.
REQ-002 SHALL have parameter PKT_BYTES, default 64: fill level that marks a full packet as ready; at most DEPTH.
REQ-003 SHALL have port clk, in, 1: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port n_rst, in, 1: asynchronous active-low reset.
REQ-005 SHALL have port clear, in, 1: synchronous flush.
REQ-006 SHALL have port wr_en, in, 1: push strobe from the SD side.
REQ-007 SHALL have port wr_data, in, 8: byte to push.
REQ-008 SHALL have port wr_last, in, 1: qualifies wr_en; the pushed byte ends the packet.
REQ-009 SHALL have port fifo_en, in, 1: pop strobe from the USB transmitter.
REQ-010 SHALL have port parallel_in, out, 8: head byte (show-ahead) to the transmitter.
REQ-011 SHALL have port buff_empty, out, 1: no bytes stored.
REQ-012 SHALL have port buff_full, out, 1: count equals DEPTH.
REQ-013 SHALL have port count, out, log2(DEPTH)+1: bytes stored.
REQ-014 SHALL have port pkt_ready, out, 1: a packet is available to send.
REQ-015 SHALL have port crc16, out, 16: USB data CRC of all bytes popped since the last clear.
REQ-016 SHALL have port overflow, out, 1: sticky push-while-full flag.
REQ-017 SHALL have port underflow, out, 1: sticky pop-while-empty flag.

Function
REQ-018 SHALL be a circular buffer with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0 without a gap.
REQ-019 SHALL accept a push (wr_en=1 and not full) at the clock edge; the byte is readable on parallel_in from the next cycle if it becomes the head.
REQ-020 SHALL drive parallel_in as mem[rd_ptr] combinationally while non-empty, and 0x00 while empty.
REQ-021 SHALL accept a pop (fifo_en=1 and not empty) at the clock edge, advancing rd_ptr so that the next byte appears in the following cycle.
REQ-022 SHALL, on push and pop in the same cycle with neither blocked, perform both and leave count unchanged.
REQ-023 SHALL, when full with push and pop together, perform both; overflow is not set.
REQ-024 SHALL, on push while full without a pop, drop the byte and set overflow.
REQ-025 SHALL, on pop while empty, ignore the pop and set underflow; this includes a push in the same cycle, where the push still completes.
REQ-026 SHALL register buff_empty, buff_full and count, updating them in the same edge as the pointers.
REQ-027 SHALL set pkt_ready on the edge where an accepted push has wr_last=1, or where count becomes at least PKT_BYTES.
REQ-028 SHALL clear pkt_ready on the edge where count becomes 0, unless an accepted push with wr_last occurs in that cycle.
REQ-029 SHALL update a 16-bit CRC register on every accepted pop, using the popped byte LSB-first.
REQ-030 SHALL use polynomial x^16+x^15+x^2+1 (0x8005, reflected 0xA001) with initial value 0xFFFF for the CRC.
REQ-031 SHALL drive crc16 as the bitwise inverse of the CRC register; bits [7:0] are sent first.
REQ-032 SHALL make crc16 reflect a pop one cycle after that pop's clock edge.
REQ-033 SHALL, on clear=1, zero both pointers, count, pkt_ready, overflow and underflow, and load 0xFFFF into the CRC register.
REQ-034 SHALL give clear priority over wr_en and fifo_en in the same cycle; neither strobe takes effect.
REQ-035 SHALL leave memory contents unreset and unobservable except through parallel_in while non-empty.

Reset
REQ-036 SHALL, on n_rst low, set immediately and asynchronously: pointers=0, count=0, buff_empty=1, buff_full=0, pkt_ready=0, overflow=0, underflow=0, CRC register=0xFFFF (crc16=0x0000), parallel_in=0x00.
REQ-037 SHALL, when reset asserts mid-transfer, discard all stored bytes, with normal operation from the first rising edge after release.

Verification
REQ-038 SHALL cover: reset with no traffic -> buff_empty=1, count=0, crc16=0x0000, pkt_ready=0.
REQ-039 SHALL cover: push 0xA5, 0x3C -> one cycle later parallel_in=0xA5, count=2; pop -> next cycle parallel_in=0x3C, count=1.
REQ-040 SHALL cover: push 64 bytes 0x00..0x3F with DEPTH=64 -> buff_full=1 and pkt_ready=1; a further push sets overflow=1 with count=64; pop all 64 -> values 0x00..0x3F in order across pointer wrap, then buff_empty=1 and pkt_ready=0.
REQ-041 SHALL cover: simultaneous push/pop at full -> count stays 64, overflow stays 0; pop while empty -> underflow=1, count=0.
REQ-042 SHALL cover: push 0x00,0x01,0x02,0x03 with wr_last on 0x03 -> pkt_ready=1 at count=4; pop all -> crc16 equals the golden reflected-CRC16 model.
REQ-043 SHALL cover: clear asserted together with wr_en and fifo_en at count=5 -> next cycle count=0, crc16=0x0000, flags=0.
